// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
  localparam int LOADER_ADDR_STEP = 4;
  localparam int LOADER_DATA_W    = 32;
endpackage

// File: rtl/loader_checksum.sv
// Wrapping sum of the words written during a session.
module loader_checksum
  import loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [LOADER_DATA_W-1:0] data,
  output logic [LOADER_DATA_W-1:0] sum
);
  always_ff @(posedge clk) begin
    if (rst || clear) sum <= '0;
    else if (enable)  sum <= sum + data;
  end
endmodule

// File: rtl/program_loader.sv
// Streams valid/ready words into processor memory through the load port.
// LOADER_CHECKSUM_EN builds the checksum accumulator; otherwise checksum is 0.
module program_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              baseAddr,
  input  logic                     wordValid,
  input  logic [LOADER_DATA_W-1:0] wordData,
  input  logic                     wordLast,
  output logic                     wordReady,
  output logic                     load,
  output logic [31:0]              addrToLoad,
  output logic [LOADER_DATA_W-1:0] instToLoad,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [CNT_W-1:0]         wordCount,
  output logic [LOADER_DATA_W-1:0] checksum
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t      state;
  logic [31:0] addr;
  logic        acc, room;

  assign wordReady = (state == LOAD);
  assign acc       = wordReady && wordValid;
  assign room      = wordCount < MAX_CNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      load       <= 1'b0;
      addrToLoad <= '0;
      instToLoad <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      wordCount  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          addr      <= baseAddr & ~32'h3;
          wordCount <= '0;
          overflow  <= 1'b0;
          busy      <= 1'b1;
        end
        LOAD: if (acc) begin
          // Once full, extra words are still accepted so the source never stalls.
          if (room) begin
            addrToLoad <= addr;
            instToLoad <= wordData;
            load       <= 1'b1;
            addr       <= addr + 32'(LOADER_ADDR_STEP);
            wordCount  <= wordCount + CNT_W'(1);
          end else begin
            overflow <= 1'b1;
          end
          if (wordLast) state <= FINISH;
        end
        FINISH: begin
          load  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic wr, clr;
  assign wr  = acc && room;
  assign clr = (state == IDLE) && start;

  loader_checksum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .enable(wr),
    .data  (wordData),
    .sum   (checksum)
  );
`else
  assign checksum = '0;
`endif
endmodule
